// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch, data) in front of a single-port unified memory.
// Data wins conflicts until fetch has lost STARVE_MAX cycles in a row, then fetch is forced.
// Read responses come back one cycle after the grant, steered by a registered tag.
module mem_arbiter #(
    parameter int unsigned MEM_WORDS  = 1024,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    // instruction fetch port
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    // data port
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    // error flag
    output logic        addr_err,
    // memory side
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned     CntW        = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CntW-1:0] StarveLimit = CntW'(STARVE_MAX);
    // 33 bits so 4*MEM_WORDS cannot wrap when the memory spans the full address space
    localparam logic [32:0]     ByteLimit   = 33'(MEM_WORDS) << 2;

    typedef enum logic [1:0] {
        TagNone  = 2'd0,
        TagFetch = 2'd1,
        TagData  = 2'd2
    } tag_e;

    tag_e            tag_q, tag_d;
    logic [CntW-1:0] starve_q, starve_d;
    logic            err_q, err_d;
    logic [31:0]     if_rdata_q, d_rdata_q;

    logic            fetch_wins;
    logic            any_gnt;
    logic            sel_we;
    logic [31:0]     sel_addr;
    logic            bad_addr;
    logic [31:0]     resp_data;

    // Grant decision and memory request steering for the current cycle
    always_comb begin
        fetch_wins = if_req && (!d_req || (starve_q == StarveLimit));
        if_gnt     = rst_n && fetch_wins;
        d_gnt      = rst_n && d_req && !fetch_wins;
        any_gnt    = if_gnt || d_gnt;
        sel_we     = d_gnt && d_we;
        sel_addr   = d_gnt ? d_addr : if_addr;
        bad_addr   = ({1'b0, sel_addr} >= ByteLimit) || (sel_addr[1:0] != 2'b00);
        // Bad accesses are still granted; they simply never reach the memory
        mem_en     = any_gnt && !bad_addr;
        mem_we     = mem_en && sel_we;
        mem_addr   = {2'b00, sel_addr[31:2]};
        mem_wdata  = d_wdata;
    end

    // Next-state: starvation counter, response tag and error flag for the access in flight
    always_comb begin
        starve_d = starve_q;
        tag_d    = TagNone;
        err_d    = any_gnt && bad_addr;
        if (!if_req || if_gnt) begin
            starve_d = '0;
        end else if (starve_q != StarveLimit) begin
            starve_d = starve_q + CntW'(1);
        end
        if (if_gnt) begin
            tag_d = TagFetch;
        end else if (d_gnt && !d_we) begin
            tag_d = TagData;
        end
    end

    // Response outputs: gated by rst_n so a reset right after a read kills its response
    always_comb begin
        if_valid  = rst_n && (tag_q == TagFetch);
        d_valid   = rst_n && (tag_q == TagData);
        addr_err  = rst_n && err_q;
        resp_data = err_q ? 32'h0 : mem_rdata;
        if_rdata  = !rst_n ? 32'h0 : (if_valid ? resp_data : if_rdata_q);
        d_rdata   = !rst_n ? 32'h0 : (d_valid ? resp_data : d_rdata_q);
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_q   <= '0;
            tag_q      <= TagNone;
            err_q      <= 1'b0;
            if_rdata_q <= 32'h0;
            d_rdata_q  <= 32'h0;
        end else begin
            starve_q   <= starve_d;
            tag_q      <= tag_d;
            err_q      <= err_d;
            if_rdata_q <= if_rdata;
            d_rdata_q  <= d_rdata;
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 1024, the number of 32-bit words in the unified memory.
REQ-002 The block SHALL have parameter STARVE_MAX, default 4, the consecutive fetch-loss count that forces a fetch grant.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, a synchronous, active-low reset.
REQ-005 The block SHALL have port if_req, input, 1 bit, an instruction-fetch request.
REQ-006 The block SHALL have port if_addr, input, 32 bits, the fetch byte address.
REQ-007 The block SHALL have port if_gnt, output, 1 bit, the fetch grant for this cycle.
REQ-008 The block SHALL have port if_valid, output, 1 bit, the fetch read data valid.
REQ-009 The block SHALL have port if_rdata, output, 32 bits, the fetch read data.
REQ-010 The block SHALL have port d_req, input, 1 bit, a data-access request.
REQ-011 The block SHALL have port d_we, input, 1 bit, the data write enable (1=store, 0=load).
REQ-012 The block SHALL have port d_addr, input, 32 bits, the data byte address.
REQ-013 The block SHALL have port d_wdata, input, 32 bits, the store data.
REQ-014 The block SHALL have port d_gnt, output, 1 bit, the data grant for this cycle.
REQ-015 The block SHALL have port d_valid, output, 1 bit, the load data valid.
REQ-016 The block SHALL have port d_rdata, output, 32 bits, the load data.
REQ-017 The block SHALL have port addr_err, output, 1 bit, a one-cycle pulse flagging an out-of-range or misaligned granted access.
REQ-018 The block SHALL have port mem_en, output, 1 bit, the memory access enable.
REQ-019 The block SHALL have port mem_we, output, 1 bit, the memory write enable.
REQ-020 The block SHALL have port mem_addr, output, 32 bits, the memory word index (byte address >> 2).
REQ-021 The block SHALL have port mem_wdata, output, 32 bits, the memory write data.
REQ-022 The block SHALL have port mem_rdata, input, 32 bits, the memory read data, valid one cycle after a read.

Function
REQ-023 The block SHALL grant at most one requester per cycle, so if_gnt and d_gnt are never both 1.
REQ-024 Grant decision SHALL be combinational from the requests and starve_cnt; mem_en/mem_we/mem_addr/mem_wdata SHALL be driven from the granted requester in the same cycle.
REQ-025 Only one request present: that requester SHALL be granted.
REQ-026 Both requests present with starve_cnt < STARVE_MAX: data SHALL be granted.
REQ-027 Both requests present with starve_cnt == STARVE_MAX: fetch SHALL be granted.
REQ-028 starve_cnt SHALL increment on each cycle where if_req=1 and if_gnt=0, saturating at STARVE_MAX.
REQ-029 starve_cnt SHALL clear on any cycle with if_gnt=1 or if_req=0.
REQ-030 Read latency SHALL be 1 cycle: a granted read in cycle N asserts the matching *_valid in cycle N+1, with *_rdata = mem_rdata.
REQ-031 The block SHALL hold a registered response tag (none/fetch/data) for the access in flight.
REQ-032 A granted store SHALL produce no *_valid pulse.
REQ-033 *_rdata SHALL hold its last value while *_valid=0.
REQ-034 Byte address >= 4*MEM_WORDS or addr[1:0] != 0: the access SHALL still be granted but mem_en SHALL be 0, addr_err SHALL pulse in N+1, and any read SHALL return *_valid=1 with *_rdata=0 in N+1.
REQ-035 Back-to-back grants SHALL be supported every cycle; a response in N+1 and a new grant in N+1 SHALL coexist.
REQ-036 The requester SHALL hold req/addr/wdata stable until its grant; a request deasserted before grant is dropped silently.

Reset
REQ-037 While rst_n=0 at a rising edge: starve_cnt=0, tag=none, if_valid=0, d_valid=0, addr_err=0, if_rdata=0, d_rdata=0.
REQ-038 While rst_n=0: if_gnt=0, d_gnt=0, and mem_en=0 regardless of the requests.
REQ-039 Reset asserted in the cycle after a granted read SHALL suppress that read's valid pulse.

Verification
REQ-040 Fetch-only: if_req=1, if_addr=0x8 for 3 cycles, memory word 2=0x20020004 -> if_gnt=1 each cycle; if_valid=1 in each following cycle with if_rdata=0x20020004.
REQ-041 Conflict: if_req=d_req=1 held with d_we=0 -> d_gnt for 4 cycles, if_gnt on the 5th, then d_gnt resumes; the pattern repeats every 5 cycles.
REQ-042 Store then load to 0x100 with d_wdata=0xDEADBEEF in consecutive cycles -> load gives d_valid=1, d_rdata=0xDEADBEEF two cycles after the store grant.
REQ-043 d_addr=0x1000 (MEM_WORDS=1024) load -> mem_en=0; next cycle addr_err=1, d_valid=1, d_rdata=0. d_addr=0x6 -> same response.
REQ-044 Granted fetch in cycle N with rst_n=0 in N+1 -> if_valid=0 in N+1; all outputs at their reset values; starve_cnt=0 after release.
